// File: rtl/memoria_arbitro_pkg.sv
// Shared types and default sizes for the two-port memory arbiter.
package memoria_arbitro_pkg;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;
endpackage

// File: rtl/memoria_arbitro_rr.sv
// Two-requester round-robin picker: one-hot grant, bit0 = A, bit1 = B.
module arbitro_rr (
    input  logic       a_req,
    input  logic       b_req,
    input  logic       last_b,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        // On a tie, whoever was not granted last wins.
        if (a_req && b_req) grant = last_b ? 2'b01 : 2'b10;
        else if (a_req)     grant = 2'b01;
        else if (b_req)     grant = 2'b10;
    end
endmodule

// File: rtl/memoria_arbitro.sv
// Arbitrates two requesters onto one external synchronous memory.
// A write occupies IDLE->ISSUE; a read IDLE->ISSUE->CAPTURE.
module memoria_arbitro
    import memoria_arbitro_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_we,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] a_ads,
    input  logic [ADDR_W-1:0] b_ads,
    input  logic [DATA_W-1:0] a_din,
    input  logic [DATA_W-1:0] b_din,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_ads,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);
    state_t     state, state_d;
    logic       last_b;
    logic       owner_b;
    logic [1:0] grant;

    arbitro_rr u_rr (
        .a_req  (a_req),
        .b_req  (b_req),
        .last_b (last_b),
        .grant  (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // mem_we holds the latched write flag while in ISSUE.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (grant != 2'b00) state_d = ISSUE;
            ISSUE:   state_d = mem_we ? IDLE : CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b   <= 1'b1;
            owner_b  <= 1'b0;
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            mem_we   <= 1'b0;
            mem_ads  <= '0;
            mem_din  <= '0;
            rdata    <= '0;
        end else begin
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE: if (grant != 2'b00) begin
                    owner_b <= grant[1];
                    last_b  <= grant[1];
                    a_gnt   <= grant[0];
                    b_gnt   <= grant[1];
                    mem_we  <= grant[1] ? b_we  : a_we;
                    mem_ads <= grant[1] ? b_ads : a_ads;
                    mem_din <= grant[1] ? b_din : a_din;
                end
                CAPTURE: begin
                    rdata    <= mem_dout;
                    a_rvalid <= !owner_b;
                    b_rvalid <= owner_b;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/memoria_arbitro.md
MEMORIA_ARBITRO -- requirements
Module: memoria_arbitro

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning the memory word-address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 64, meaning the memory word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports a_req/b_req, input, 1 bit each: requester A/B has a pending access.
REQ-006 SHALL have ports a_we/b_we, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports a_ads/b_ads, input, ADDR_W each: word address.
REQ-008 SHALL have ports a_din/b_din, input, DATA_W each: write data.
REQ-009 SHALL have ports a_gnt/b_gnt, output, 1 bit each: one-cycle pulse, command accepted.
REQ-010 SHALL have ports a_rvalid/b_rvalid, output, 1 bit each: one-cycle pulse, rdata valid for that requester.
REQ-011 SHALL have port rdata, output, DATA_W: read data shared by both requesters.
REQ-012 SHALL have ports mem_ads (ADDR_W), mem_we (1), mem_din (DATA_W), all outputs: drive the memory.
REQ-013 SHALL have port mem_dout, input, DATA_W: memory registered read data.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE and CAPTURE; reset state IDLE.
REQ-015 In IDLE with any req high, SHALL pick the winner, latch its we/ads/din, assert its gnt at the next edge and enter ISSUE.
REQ-016 SHALL use round-robin arbitration: on simultaneous a_req and b_req, the requester not granted last wins; after reset A has priority.
REQ-017 A lone request SHALL win regardless of the round-robin pointer.
REQ-018 In ISSUE, SHALL drive mem_ads/mem_din from latched values and mem_we from the latched we for exactly one cycle.
REQ-019 Outside ISSUE, mem_we SHALL be 0, and mem_ads/mem_din SHALL hold their last values.
REQ-020 A write SHALL go ISSUE -> IDLE with no rvalid pulse.
REQ-021 A read SHALL go ISSUE -> CAPTURE; in CAPTURE, SHALL register mem_dout into rdata, pulse the owner's rvalid on the next edge and return to IDLE.
REQ-022 Read latency SHALL be: request seen in IDLE at edge k -> gnt high in cycle k+1 -> rvalid and rdata valid in cycle k+3.
REQ-023 rdata SHALL hold its value until the next read capture.
REQ-024 Requesters SHALL hold req and their fields stable until gnt; the arbiter SHALL ignore req outside IDLE.
REQ-025 A requester deasserting req before gnt SHALL cause no memory access.
REQ-026 gnt and rvalid SHALL be mutually exclusive between A and B and never high for two consecutive cycles.
REQ-027 Back-to-back operation SHALL be supported: maximum one access per 2 cycles (write) or 3 cycles (read).

Reset
REQ-028 rst_n low SHALL immediately force state to IDLE and clear gnt, rvalid and mem_we to 0.
REQ-029 rst_n low SHALL clear mem_ads, mem_din and rdata to 0 and set the round-robin pointer to favour A.
REQ-030 Reset during ISSUE or CAPTURE SHALL abort the operation: no rvalid, and no write committed after the reset edge.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the ADDR_W/DATA_W default constants.
REQ-032 Round-robin selection SHALL be one sub-module, arbitro_rr (two requests + last-grant pointer -> one-hot grant).
REQ-033 The memory itself SHALL be external and not instantiated inside this block.

Verification
REQ-034 Memory model preloaded with word 16 = 45; A reads address 16 -> a_gnt in cycle k+1, a_rvalid in cycle k+3, rdata = 45, b_rvalid stays 0.
REQ-035 A writes 0xDEAD_BEEF to address 3, then B reads address 3 -> mem_we high exactly one cycle, b_rvalid with rdata = 0xDEAD_BEEF.
REQ-036 a_req and b_req held high continuously, both reads -> grants alternate A, B, A, B starting with A after reset.
REQ-037 rst_n pulsed low during CAPTURE of a read -> no rvalid, state IDLE, rdata = 0; the next request is served normally.
REQ-038 B writes 7 to address 31, then A reads address 31 while B issues a new request -> A reads 7; the round-robin pointer then serves B next.
